// File: rtl/stream_parity_unit.sv
// Streaming parity generator/checker: XOR-accumulates framed WIDTH-bit words and
// hands back one parity result per frame. Define PARITY_ERRCNT_EN for a saturating error counter.
module stream_parity_unit #(
    parameter int WIDTH   = 4,
    parameter int MAX_LEN = 16,
    parameter int ODD     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             chk_en,
    input  logic             chk_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_err,
    output logic             out_trunc,
`ifdef PARITY_ERRCNT_EN
    output logic [7:0]       err_count,
`endif
    output logic             busy
);

    localparam int               CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);
    localparam logic             ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic             chk_en_q;
    logic             chk_bit_q;

    logic             xfer;
    logic             word_par;
    logic             acc_nxt;
    logic             par_nxt;
    logic             final_word;
    logic [CNT_W-1:0] cnt_nxt;

    // IDLE starts a fresh frame, so the incoming word seeds the accumulator directly.
    always_comb begin
        xfer       = in_valid & in_ready;
        word_par   = ^in_data;
        acc_nxt    = (state == IDLE) ? word_par : (acc ^ word_par);
        cnt_nxt    = (state == IDLE) ? CNT_W'(1) : (cnt + CNT_W'(1));
        final_word = in_last | (cnt_nxt == LEN_MAX);
        par_nxt    = acc_nxt ^ ODD_BIT;
    end

    assign in_ready = (state != DONE);
    assign busy     = (state != IDLE);
    assign out_err  = chk_en_q & (out_parity != chk_bit_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            chk_en_q   <= 1'b0;
            chk_bit_q  <= 1'b0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_trunc  <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (xfer) begin
                        acc <= acc_nxt;
                        cnt <= cnt_nxt;
                        if (final_word) begin
                            state      <= DONE;
                            chk_en_q   <= chk_en;
                            chk_bit_q  <= chk_bit;
                            out_valid  <= 1'b1;
                            out_parity <= par_nxt;
                            out_trunc  <= ~in_last;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    // Check bits are cleared too so out_err cannot leak outside a valid result.
                    if (out_ready) begin
                        state      <= IDLE;
                        acc        <= 1'b0;
                        cnt        <= '0;
                        chk_en_q   <= 1'b0;
                        chk_bit_q  <= 1'b0;
                        out_valid  <= 1'b0;
                        out_parity <= 1'b0;
                        out_trunc  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PARITY_ERRCNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if ((state == DONE) && out_ready && out_err) begin
            err_count <= sat_inc8(err_count);
        end
    end
`endif

endmodule

// File: tb/tb_stream_parity_unit.sv
// Bench for stream_parity_unit: even and odd parity instances share one stimulus stream
// and are checked against a frame-level parity model.
module tb_stream_parity_unit;

    localparam int W  = 4;
    localparam int ML = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         chk_en = 1'b0;
    logic         chk_bit = 1'b0;
    logic         out_ready = 1'b0;

    logic in_ready0, out_valid0, out_parity0, out_err0, out_trunc0, busy0;
    logic in_ready1, out_valid1, out_parity1, out_err1, out_trunc1, busy1;
`ifdef PARITY_ERRCNT_EN
    logic [7:0] err_count0, err_count1;
`endif
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;
    bit cur_err0, cur_err1;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] words[$];

    always #5 clk = ~clk;

    stream_parity_unit #(.WIDTH(W), .MAX_LEN(ML), .ODD(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready0), .chk_en(chk_en), .chk_bit(chk_bit), .out_valid(out_valid0),
        .out_ready(out_ready), .out_parity(out_parity0), .out_err(out_err0),
        .out_trunc(out_trunc0),
`ifdef PARITY_ERRCNT_EN
        .err_count(err_count0),
`endif
        .busy(busy0)
    );

    stream_parity_unit #(.WIDTH(W), .MAX_LEN(ML), .ODD(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready1), .chk_en(chk_en), .chk_bit(chk_bit), .out_valid(out_valid1),
        .out_ready(out_ready), .out_parity(out_parity1), .out_err(out_err1),
        .out_trunc(out_trunc1),
`ifdef PARITY_ERRCNT_EN
        .err_count(err_count1),
`endif
        .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic check_counts(input string tag);
`ifdef PARITY_ERRCNT_EN
        chk({tag, "_errcnt0"}, err_count0, exp_cnt0);
        chk({tag, "_errcnt1"}, err_count1, exp_cnt1);
`endif
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid0"}, out_valid0, 0);
        chk({tag, "_par0"},   out_parity0, 0);
        chk({tag, "_err0"},   out_err0, 0);
        chk({tag, "_trunc0"}, out_trunc0, 0);
        chk({tag, "_busy0"},  busy0, 0);
        chk({tag, "_valid1"}, out_valid1, 0);
        chk({tag, "_par1"},   out_parity1, 0);
        chk({tag, "_err1"},   out_err1, 0);
        chk({tag, "_busy1"},  busy1, 0);
    endtask

    task automatic check_done(input string tag, input bit e, input bit ce, input bit cb, input bit tr);
        cur_err0 = ce && (e != cb);
        cur_err1 = ce && ((!e) != cb);
        chk({tag, "_valid0"}, out_valid0, 1);
        chk({tag, "_par0"},   out_parity0, e);
        chk({tag, "_err0"},   out_err0, cur_err0);
        chk({tag, "_trunc0"}, out_trunc0, tr);
        chk({tag, "_rdy0"},   in_ready0, 0);
        chk({tag, "_busy0"},  busy0, 1);
        chk({tag, "_valid1"}, out_valid1, 1);
        chk({tag, "_par1"},   out_parity1, !e);
        chk({tag, "_err1"},   out_err1, cur_err1);
        chk({tag, "_trunc1"}, out_trunc1, tr);
    endtask

    // Pushes the queued words; returns the even parity of all bits in the frame.
    task automatic send_words(input bit use_last, input bit ce, input bit cb, input bit gaps,
                              output bit e);
        int n = words.size();
        e = 1'b0;
        foreach (words[i]) e ^= ^words[i];
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                @(posedge clk); #1;
                chk("gap_busy", busy0, 1);
            end
            chk("word_rdy", in_ready0, 1);
            chk("word_nvalid", out_valid0, 0);
            in_data   = words[i];
            in_valid  = 1'b1;
            in_last   = use_last && (i == n - 1);
            chk_en    = (i == n - 1) ? ce : 1'($urandom);
            chk_bit   = (i == n - 1) ? cb : 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chk_en    = 1'($urandom);
        chk_bit   = 1'($urandom);
        out_ready = 1'b0;
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        if (cur_err0) exp_cnt0 = (exp_cnt0 < 255) ? exp_cnt0 + 1 : 255;
        if (cur_err1) exp_cnt1 = (exp_cnt1 < 255) ? exp_cnt1 + 1 : 255;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_idle({tag, "_rel"});
        chk({tag, "_rel_rdy"}, in_ready0, 1);
        check_counts(tag);
    endtask

    task automatic run_frame(input string tag, input bit use_last, input bit ce, input bit cb,
                             input int hold, input bit gaps);
        bit e;
        send_words(use_last, ce, cb, gaps, e);
        check_done(tag, e, ce, cb, !use_last);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            check_done({tag, "_hold"}, e, ce, cb, !use_last);
        end
        release_result(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        check_idle(tag);
        check_counts(tag);
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, "_rdy"}, in_ready0, 1);
    endtask

    initial begin
        bit e;
        #1 rst = 1'b1;
        #2;
        check_idle("reset");
        check_counts("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_rdy", in_ready0, 1);

        words = '{4'b1011};
        run_frame("single", 1, 0, 0, 0, 0);

        words = '{4'h3, 4'h1, 4'hF};
        run_frame("three", 1, 1, 0, 0, 0);

        for (int v = 0; v < 16; v++) begin
            words = '{W'(v)};
            run_frame("xor_tt", 1, 0, 0, 0, 0);
        end

        words.delete();
        for (int i = 0; i < ML; i++) words.push_back(4'h1);
        run_frame("trunc", 0, 0, 0, 5, 0);
        run_frame("full_last", 1, 1, 1, 0, 0);

        words = '{4'h1, 4'h1, 4'h1};
        send_words(0, 0, 0, 0, e);
        chk("partial_busy", busy0, 1);
        pulse_reset("rst_accum");

        words = '{4'h7};
        send_words(1, 1, 0, 0, e);
        check_done("pre_rst", e, 1, 0, 0);
        pulse_reset("rst_done");

        words = '{4'h2};
        run_frame("post_rst", 1, 0, 0, 0, 0);

        for (int f = 0; f < 40; f++) begin
            int  n  = $urandom_range(1, ML);
            bit  ul = 1'($urandom);
            words.delete();
            if (!ul) n = ML;
            for (int i = 0; i < n; i++) words.push_back(W'($urandom));
            run_frame("rand", ul, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1);
        end

`ifdef PARITY_ERRCNT_EN
        pulse_reset("cnt_rst");
        words = '{4'h1};
        for (int f = 0; f < 3; f++) run_frame("cnt3", 1, 1, 0, 0, 0);
        chk("cnt_three", err_count0, 3);
        for (int f = 0; f < 260; f++) run_frame("cnt_sat", 1, 1, 0, 0, 0);
        chk("cnt_sat_final", err_count0, 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
